// File: rtl/alu_seq.sv
// Handshaked ALU: single-cycle ops plus a W-cycle restoring divider; result register held until taken.
// in_ready drops while dividing or while a result is stalled by out_ready.
module alu_seq #(
  parameter int WIDTH = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic [3:0]         sel,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] result,
  output logic               carry,
  output logic               zero,
  output logic               dz
);

  localparam int W2 = 2 * WIDTH;
  localparam int CW = $clog2(WIDTH);

  localparam logic [3:0] OP_ADD  = 4'h0;
  localparam logic [3:0] OP_SUB  = 4'h1;
  localparam logic [3:0] OP_MUL  = 4'h2;
  localparam logic [3:0] OP_DIV  = 4'h3;
  localparam logic [3:0] OP_AND  = 4'h4;
  localparam logic [3:0] OP_OR   = 4'h5;
  localparam logic [3:0] OP_NAND = 4'h6;
  localparam logic [3:0] OP_NOR  = 4'h7;
  localparam logic [3:0] OP_SHL  = 4'h8;
  localparam logic [3:0] OP_SHR  = 4'h9;
  localparam logic [3:0] OP_ROL  = 4'hA;
  localparam logic [3:0] OP_ROR  = 4'hB;
  localparam logic [3:0] OP_XOR  = 4'hC;
  localparam logic [3:0] OP_XNOR = 4'hD;
  localparam logic [3:0] OP_GT   = 4'hE;
  localparam logic [3:0] OP_EQ   = 4'hF;

  typedef enum logic {
    S_IDLE,
    S_DIV
  } state_t;

  state_t state, state_d;

  logic              accept, start_div, div_done;
  logic [W2-1:0]     ax, bx, alu_res, div_res;
  logic              alu_c, alu_dz;

  logic [WIDTH-1:0]  dvs, quo, quo_nx;
  logic [WIDTH:0]    rem, rem_nx;
  logic [WIDTH+1:0]  shifted, trial;
  logic              fits;
  logic [CW-1:0]     cnt;

  assign in_ready  = (state == S_IDLE) && (!out_valid || out_ready);
  assign accept    = in_valid && in_ready;
  assign start_div = accept && (sel == OP_DIV) && (b != '0);
  assign div_done  = (state == S_DIV) && (cnt == '0);

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_d;
  end

  always_comb begin
    state_d = state;
    case (state)
      S_IDLE: if (start_div) state_d = S_DIV;
      S_DIV:  if (div_done)  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign ax = {{WIDTH{1'b0}}, a};
  assign bx = {{WIDTH{1'b0}}, b};

  always_comb begin
    alu_res = '0;
    alu_c   = 1'b0;
    alu_dz  = 1'b0;
    case (sel)
      OP_ADD: begin
        alu_res = ax + bx;
        alu_c   = alu_res[WIDTH];
      end
      OP_SUB: begin
        alu_res = {{WIDTH{1'b0}}, a - b};
        alu_c   = (a < b);
      end
      OP_MUL:  alu_res = ax * bx;
      // Only reaches the output register when b is zero; nonzero divisors go iterative.
      OP_DIV:  alu_dz  = 1'b1;
      OP_AND:  alu_res = ax & bx;
      OP_OR:   alu_res = ax | bx;
      OP_NAND: alu_res = {{WIDTH{1'b0}}, ~(a & b)};
      OP_NOR:  alu_res = {{WIDTH{1'b0}}, ~(a | b)};
      OP_SHL:  alu_res = ax << 1;
      OP_SHR:  alu_res = ax >> 1;
      OP_ROL:  alu_res = {{WIDTH{1'b0}}, a[WIDTH-2:0], a[WIDTH-1]};
      OP_ROR:  alu_res = {{WIDTH{1'b0}}, a[0], a[WIDTH-1:1]};
      OP_XOR:  alu_res = ax ^ bx;
      OP_XNOR: alu_res = {{WIDTH{1'b0}}, ~(a ^ b)};
      OP_GT:   alu_res[0] = (a > b);
      OP_EQ:   alu_res[0] = (a == b);
      default: alu_res = '0;
    endcase
  end

  // Restoring step: shift the next dividend bit into the remainder, subtract if it fits.
  assign shifted = {rem, quo[WIDTH-1]};
  assign trial   = shifted - {2'b00, dvs};
  assign fits    = !trial[WIDTH+1];
  assign rem_nx  = fits ? trial[WIDTH:0] : shifted[WIDTH:0];
  assign quo_nx  = {quo[WIDTH-2:0], fits};
  assign div_res = {rem_nx[WIDTH-1:0], quo_nx};

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      result    <= '0;
      carry     <= 1'b0;
      zero      <= 1'b0;
      dz        <= 1'b0;
      dvs       <= '0;
      quo       <= '0;
      rem       <= '0;
      cnt       <= '0;
    end else begin
      if (start_div) begin
        dvs <= b;
        quo <= a;
        rem <= '0;
        cnt <= CW'(WIDTH - 1);
      end else if (state == S_DIV) begin
        quo <= quo_nx;
        rem <= rem_nx;
        cnt <= cnt - 1'b1;
      end

      if (accept && !start_div) begin
        out_valid <= 1'b1;
        result    <= alu_res;
        carry     <= alu_c;
        zero      <= (alu_res == '0);
        dz        <= alu_dz;
      end else if (div_done) begin
        out_valid <= 1'b1;
        result    <= div_res;
        carry     <= 1'b0;
        zero      <= (div_res == '0);
        dz        <= 1'b0;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Randomised and directed bench for alu_seq at WIDTH=16 and WIDTH=8 against an arithmetic reference.
module tb_alu_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        in_valid, in_ready, out_valid, out_ready, carry, zero, dz;
  logic [15:0] a, b;
  logic [3:0]  sel;
  logic [31:0] result;

  logic        in_valid8, in_ready8, out_valid8, out_ready8, carry8, zero8, dz8;
  logic [7:0]  a8, b8;
  logic [3:0]  sel8;
  logic [15:0] result8;

  alu_seq #(.WIDTH(16)) u16 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .sel(sel), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .carry(carry), .zero(zero), .dz(dz)
  );

  alu_seq #(.WIDTH(8)) u8 (
    .clk(clk), .rst(rst), .in_valid(in_valid8), .in_ready(in_ready8),
    .a(a8), .b(b8), .sel(sel8), .out_valid(out_valid8), .out_ready(out_ready8),
    .result(result8), .carry(carry8), .zero(zero8), .dz(dz8)
  );

  typedef struct {
    logic [63:0] res;
    logic        c;
    logic        dz;
  } exp_t;

  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc = 0;
  int   n_out16 = 0;
  bit   rand_bp = 1'b0;
  exp_t q16[$];
  exp_t mon_e;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference: plain unsigned arithmetic on w-bit operands.
  function automatic exp_t model(input int w, input longint unsigned x, input longint unsigned y,
                                 input logic [3:0] s);
    exp_t e;
    longint unsigned m;
    m = (64'd1 << w) - 1;
    e.res = 0; e.c = 1'b0; e.dz = 1'b0;
    case (s)
      4'h0: begin e.res = x + y; e.c = e.res[w]; end
      4'h1: begin e.res = (x - y) & m; e.c = (x < y); end
      4'h2: e.res = x * y;
      4'h3: if (y == 0) e.dz = 1'b1; else e.res = ((x % y) << w) | (x / y);
      4'h4: e.res = x & y;
      4'h5: e.res = x | y;
      4'h6: e.res = ~(x & y) & m;
      4'h7: e.res = ~(x | y) & m;
      4'h8: e.res = x << 1;
      4'h9: e.res = x >> 1;
      4'hA: e.res = ((x << 1) | (x >> (w - 1))) & m;
      4'hB: e.res = (x >> 1) | ((x & 1) << (w - 1));
      4'hC: e.res = x ^ y;
      4'hD: e.res = ~(x ^ y) & m;
      4'hE: e.res = (x > y) ? 1 : 0;
      default: e.res = (x == y) ? 1 : 0;
    endcase
    return e;
  endfunction

  // Every transfer on the 16-bit output is matched in order against the expected queue.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      n_out16++;
      if (q16.size() == 0) begin
        chk("unexpected_output", 1, 0);
      end else begin
        mon_e = q16.pop_front();
        chk("stream_result", result, mon_e.res);
        chk("stream_flags", {carry, zero, dz}, {mon_e.c, (mon_e.res == 0), mon_e.dz});
      end
    end
  end

  always begin
    @(posedge clk);
    #1;
    if (rand_bp) out_ready = ($urandom_range(0, 3) != 0);
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  task automatic send16(input logic [15:0] xa, input logic [15:0] xb, input logic [3:0] xs);
    int t;
    t = 0;
    in_valid = 1'b1; a = xa; b = xb; sel = xs;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      t++;
      if (t > 200) begin
        chk("accept_timeout", 0, 1);
        in_valid = 1'b0;
        return;
      end
    end
    @(posedge clk);
    q16.push_back(model(16, xa, xb, xs));
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_valid(input int maxc, output int edges, output int irl);
    edges = 0;
    irl = 0;
    forever begin
      @(negedge clk);
      if (!in_ready) irl++;
      if (out_valid) return;
      edges++;
      if (edges > maxc) begin
        chk("valid_timeout", 0, 1);
        return;
      end
    end
  endtask

  task automatic drain16();
    int t;
    t = 0;
    while (q16.size() != 0 && t < 300) begin
      @(posedge clk);
      t++;
    end
    #1;
    chk("queue_drained", q16.size(), 0);
  endtask

  task automatic op8(input logic [7:0] xa, input logic [7:0] xb, input logic [3:0] xs);
    exp_t e;
    int   t;
    e = model(8, xa, xb, xs);
    t = 0;
    in_valid8 = 1'b1; a8 = xa; b8 = xb; sel8 = xs;
    forever begin
      @(negedge clk);
      if (in_ready8) break;
      t++;
      if (t > 100) begin
        chk("accept8_timeout", 0, 1);
        in_valid8 = 1'b0;
        return;
      end
    end
    @(posedge clk);
    #1;
    in_valid8 = 1'b0;
    t = 0;
    forever begin
      @(negedge clk);
      if (out_valid8) break;
      t++;
      if (t > 40) begin
        chk("valid8_timeout", 0, 1);
        return;
      end
    end
    chk($sformatf("w8_op%0h_result", xs), result8, e.res);
    chk($sformatf("w8_op%0h_flags", xs), {carry8, zero8, dz8}, {e.c, (e.res == 0), e.dz});
    sync();
  endtask

  initial begin
    int ed, irl, seen, held, t0, n0;
    logic [15:0] ra, rb;
    logic [3:0]  rs;

    rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; sel = '0; out_ready = 1'b1;
    in_valid8 = 1'b0; a8 = '0; b8 = '0; sel8 = '0; out_ready8 = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_out_valid", out_valid, 0);
    chk("reset_result", result, 0);
    chk("reset_flags", {carry, zero, dz}, 0);
    chk("reset_in_ready", in_ready, 1);
    sync();

    send16(16'hFFFF, 16'h0001, 4'h0);
    wait_valid(40, ed, irl);
    chk("add_latency", ed, 0);
    chk("add_result", result, 32'h0001_0000);
    chk("add_flags", {carry, zero, dz}, 3'b100);
    sync();

    // A stalled result must be wiped by a reset pulse.
    out_ready = 1'b0;
    send16(16'h1234, 16'h1111, 4'h5);
    wait_valid(40, ed, irl);
    sync();
    rst = 1'b1;
    sync();
    rst = 1'b0;
    q16.delete();
    @(negedge clk);
    chk("rstpulse_out_valid", out_valid, 0);
    chk("rstpulse_result", result, 0);
    chk("rstpulse_flags", {carry, zero, dz}, 0);
    sync();
    out_ready = 1'b1;

    send16(16'h0003, 16'h0005, 4'h1);
    wait_valid(40, ed, irl);
    chk("sub_result", result, 32'h0000_FFFE);
    chk("sub_borrow", carry, 1);
    sync();
    send16(16'hFFFF, 16'hFFFF, 4'h2);
    wait_valid(40, ed, irl);
    chk("mul_result", result, 32'hFFFE_0001);
    sync();

    send16(16'd1000, 16'd7, 4'h3);
    wait_valid(40, ed, irl);
    chk("div_latency", ed, 16);
    chk("div_in_ready_low", irl, 16);
    chk("div_quotient", result[15:0], 142);
    chk("div_remainder", result[31:16], 6);
    sync();
    send16(16'd5, 16'd0, 4'h3);
    wait_valid(40, ed, irl);
    chk("divzero_latency", ed, 0);
    chk("divzero_result", result, 0);
    chk("divzero_flags", {carry, zero, dz}, 3'b011);
    sync();

    send16(16'hFFFF, 16'd3, 4'h3);
    repeat (5) @(posedge clk);
    #1 rst = 1'b1;
    sync();
    rst = 1'b0;
    q16.delete();
    @(negedge clk);
    chk("abort_in_ready", in_ready, 1);
    seen = 0;
    repeat (20) begin
      if (out_valid) seen++;
      @(negedge clk);
    end
    chk("abort_no_output", seen, 0);
    sync();
    send16(16'd2, 16'd2, 4'h0);
    wait_valid(40, ed, irl);
    chk("add_after_abort", result, 4);
    sync();

    out_ready = 1'b0;
    send16(16'h8001, 16'h0000, 4'hA);
    held = 0;
    repeat (10) begin
      @(negedge clk);
      if (out_valid && result == 32'h3 && !in_ready) held++;
    end
    chk("backpressure_hold", held, 10);
    sync();
    out_ready = 1'b1;

    t0 = cyc;
    n0 = n_out16;
    for (int i = 0; i < 24; i++) begin
      ra = 16'($urandom);
      rb = ($urandom_range(0, 1) == 0) ? ra : 16'($urandom);
      case ($urandom_range(0, 2))
        0:       rs = 4'hC;
        1:       rs = 4'hF;
        default: rs = 4'hE;
      endcase
      send16(ra, rb, rs);
    end
    chk("stream_accept_cycles", cyc - t0, 24);
    drain16();
    chk("stream_output_count", n_out16 - n0, 25);

    rand_bp = 1'b1;
    for (int i = 0; i < 300; i++) begin
      ra = 16'($urandom);
      rb = ($urandom_range(0, 7) == 0) ? 16'h0 : 16'($urandom);
      send16(ra, rb, 4'($urandom_range(0, 15)));
    end
    rand_bp = 1'b0;
    out_ready = 1'b1;
    drain16();

    for (int i = 0; i < 200; i++) begin
      op8(8'($urandom), ($urandom_range(0, 7) == 0) ? 8'h0 : 8'($urandom), 4'(i % 16));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/alu_seq.md
# alu_seq

Parametrised, handshaked successor to the team's 16-bit registered ALU. It keeps the same 4-bit opcode map and adds several features:
- configurable operand width;
- valid/ready flow control on input and output;
- a full-width product;
- an iterative restoring divider that returns quotient and remainder;
- status flags.

It sits between the instruction-issue logic and the writeback stage. Any number of stall cycles is tolerated on either side.

## Interface
Parameters:
- WIDTH, 16, operand width in bits (legal range 4..32).

Ports:
- clk  in  1  clock; all state changes on rising edge.
- rst  in  1  reset; synchronous, active-high.
- in_valid  in  1  operand/opcode presented.
- in_ready  out  1  block can accept; transfer when in_valid && in_ready at a rising edge.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- sel  in  4  opcode.
- out_valid  out  1  result/flags valid; held until taken.
- out_ready  in  1  consumer accepts; transfer when out_valid && out_ready.
- result  out  2*WIDTH  result, zero-extended unless stated.
- carry  out  1  carry/borrow of add/sub; 0 for all other ops.
- zero  out  1  result == 0 (all 2*WIDTH bits).
- dz  out  1  divide by zero; 0 for all other ops.

## Operation
Opcode map (unsigned; W = WIDTH):
- 0000: ADD. result = a+b as W+1 bits; carry = bit W.
- 0001: SUB. result = (a-b) mod 2^W; carry = (a<b).
- 0010: MUL. Full 2W-bit product.
- 0011: DIV. result[W-1:0] = a/b, result[2W-1:W] = a%b.
- 0100: AND.
- 0101: OR.
- 0110: NAND, W bits.
- 0111: NOR, W bits.
- 1000: SHL. (a<<1) as W+1 bits, so MSB is kept in bit W.
- 1001: SHR.
- 1010: ROL by 1.
- 1011: ROR by 1.
- 1100: XOR.
- 1101: XNOR, W bits.
- 1110: GT, (a>b) in bit 0.
- 1111: EQ, (a==b) in bit 0.

Inverting ops (NAND/NOR/XNOR) produce W bits; upper bits are 0.

States:
- IDLE: accepts new operations.
- DIV: iterative divide in progress.

Accept path:
- in_ready = (state==IDLE) && (!out_valid || out_ready).
- Operands and sel are captured only on acceptance; input changes afterward are ignored.

Non-DIV ops, and DIV with b==0:
- Computed in one step; output register loaded at the accept edge; state stays IDLE.
- DIV by zero: result=0, dz=1, zero=1.

DIV with b!=0:
- Transition to DIV.
- Restoring algorithm, one quotient bit per cycle, MSB first, W iterations.
- Remainder register is W+1 bits. The divisor is held in a register.
- On the final iteration: load output register, return to IDLE.

Output register:
- {result, carry, zero, dz, out_valid} is updated only on an accept-completion or a consume.
- If consumed (out_valid && out_ready) with no new completion in the same cycle, out_valid clears; data is don't-care but stays held.
- Consume and new completion in the same edge: new result loads and out_valid stays 1.

Reset:
- Resets all outputs to 0, out_valid=0, state=IDLE.
- Mid-DIV reset aborts the division; no result is emitted.
- in_ready=1 in the first cycle after reset release.

## Timing
- Non-DIV / divide-by-zero latency: 1. Accepted at edge k, so out_valid=1 after edge k.
- Throughput is 1 op/cycle with out_ready held high.
- DIV latency: W cycles. Accepted at edge k, out_valid=1 after edge k+W.
- in_ready=0 from edge k through edge k+W-1.
- Back-pressure:
  - While out_valid && !out_ready, in_ready=0.
  - result, flags and out_valid hold stable.
- in_ready is combinational from state, out_valid and out_ready. There is no combinational path from in_valid to out_*.

## Test plan
1. Reset, then ADD. W=16, a=0xFFFF, b=0x0001, sel=0000 → one cycle later: result=0x10000, carry=1, zero=0, dz=0. Mid-stream rst pulse → all outputs 0 next edge.
2. SUB borrow and MUL.
   - a=0x0003, b=0x0005, sel=0001 → result=0xFFFE, carry=1.
   - a=0xFFFF, b=0xFFFF, sel=0010 → result=0xFFFE0001.
3. DIV timing.
   - a=1000, b=7, sel=0011 → in_ready low 16 cycles; out_valid exactly 16 cycles after accept; result[15:0]=142, result[31:16]=6.
   - Then a=5, b=0 → 1-cycle latency, result=0, dz=1, zero=1.
4. Abort.
   - DIV a=0xFFFF, b=3; assert rst after 5 cycles → no out_valid; in_ready=1 after release.
   - Next ADD 2+2 → result=4.
5. Back-pressure and back-to-back.
   - out_ready=0 with ROL a=0x8001 → result=0x0003 held and in_ready=0 for 10 cycles.
   - Then out_ready=1 with a stream of XOR/EQ/GT ops → one result per cycle, in order, none lost or duplicated.
   - Also sweep all 16 opcodes against a reference model for random operands at WIDTH=8 and 16.
